ram_access_arbiter: RTL and testbench
=====================================

Name: ram_access_arbiter

Overview:
- Request arbiter that sits directly upstream of the 128-bit, byte-enabled, unaligned-address data RAM (20-bit byte address, 16 byte lanes, 1-cycle read latency).
- Merges two clients onto the single RAM port:
  - client 0: CPU load/store unit, read and write.
  - client 1: HDMI frame reader, read-only.
- Tracks reads in flight and returns each read response, registered, to the client that issued it.

Parameters:
- READ_LATENCY, 1: cycles from a RAM address edge to valid ram_data_out; legal range 1..4.
- ADDR_W, 20: byte-address width.
- DATA_W, 128: data width; byte-enable width is DATA_W/8.

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req_valid  in  1  CPU request present.
- cpu_req_ready  out  1  CPU request accepted this cycle.
- cpu_req_write  in  1  1 = write, 0 = read.
- cpu_req_address  in  ADDR_W  byte address; unaligned is allowed.
- cpu_req_data  in  DATA_W  write data.
- cpu_req_byte_enablers  in  DATA_W/8  write byte lanes.
- cpu_resp_valid  out  1  one-cycle pulse: read data valid.
- cpu_resp_data  out  DATA_W  read data; held until the next CPU response.
- vid_req_valid  in  1  video read request present.
- vid_req_ready  out  1  video request accepted this cycle.
- vid_req_address  in  ADDR_W  byte address.
- vid_resp_valid  out  1  one-cycle pulse: read data valid.
- vid_resp_data  out  DATA_W  read data; held until the next video response.
- ram_address  out  ADDR_W  to RAM address.
- ram_data_in  out  DATA_W  to RAM data_in.
- ram_byte_enablers  out  DATA_W/8  to RAM byte_enablers.
- ram_write_enable  out  1  to RAM write_enable.
- ram_data_out  in  DATA_W  from RAM data_out.

Behaviour:
- Clocking: one clock, clock; reset is synchronous and active-high.
- Reset values: cpu_req_ready=0, vid_req_ready=0, cpu_resp_valid=0, vid_resp_valid=0, cpu_resp_data=0, vid_resp_data=0, ram_write_enable=0, ram_address=0, ram_data_in=0, ram_byte_enablers=0. The last-grant pointer resets to "video", so the CPU wins the first conflict.
- Arbitration (combinational, every cycle):
  - Exactly one grant or none.
  - If only one client is valid, it is granted.
  - If both are valid, round robin: the client not granted last wins.
  - The last-grant pointer updates only on a cycle with a grant.
  - ready = grant; a transfer occurs when valid && ready.
  - Requesters hold all request fields stable while valid && !ready.
- RAM drive:
  - The granted client's fields drive the ram_* outputs combinationally.
  - ram_write_enable = grant_cpu && cpu_req_write.
  - Video requests force ram_write_enable=0 and ram_byte_enablers=0.
  - With no grant, ram_write_enable=0 and the other ram_* outputs hold their last values.
- Read tracking:
  - A shift pipe of READ_LATENCY entries, each {valid, client_id}.
  - An entry is pushed on each accepted read; writes push valid=0.
  - The tail entry's valid qualifies ram_data_out, which is captured into the owning client's resp_data register.
  - The owner's resp_valid pulses on the following cycle.
  - Total read latency: accept edge -> resp_valid high READ_LATENCY+1 cycles later (2 at default).
- Throughput: one request per cycle, sustained. Back-to-back reads from alternating clients return in issue order, with no bubbles.
- No response backpressure: clients must sink every response pulse.
- Read after write: a CPU write accepted in cycle N followed by any read in cycle N+1 returns the new data. The RAM's write-then-read ordering guarantees this, so the arbiter adds no hazard logic.
- Simultaneous requests: only the loser stalls; the winner's response timing is unaffected.
- Reset mid-operation: every in-flight pipe entry is dropped, and no resp_valid fires for requests accepted before reset. resp_data registers clear.
- Writes never generate a response.

Optional Feature:
- Macro: VIDEO_PRIORITY_EN.
- Defined: client 1 wins every conflict (fixed priority, to keep the HDMI line deadline), and the CPU is granted only when vid_req_valid=0. The last-grant pointer is unused, and CPU starvation is allowed.
- Undefined: round-robin arbitration as specified above.

Test Plan:
- Reset, then single CPU read of address 0x00013 after preloading bytes 0x13..0x22 with 0x00..0x0F -> cpu_resp_valid exactly 2 cycles after accept; cpu_resp_data byte lanes = 0x0F..0x00 (lane 0 = 0x00); vid_resp_valid stays 0.
- CPU write to 0x00005 (data 0x11 repeated, byte_enablers=0x000F), then CPU read 0x00004 in the next cycle -> ram_write_enable high one cycle; read returns byte lane 0 unchanged and lanes 1..4 = 0x11.
- Both clients valid for 6 consecutive cycles from reset -> grants alternate C,V,C,V,C,V; responses return to the matching client in that order, one per cycle, with no duplicates.
- Video request with fabricated nonzero byte enables via the interface -> ram_write_enable=0 and ram_byte_enablers=0 throughout; RAM contents unchanged.
- Two reads accepted, then reset asserted one cycle later for 1 cycle -> no resp_valid on either client afterward; all outputs read 0 the cycle after reset.
- VIDEO_PRIORITY_EN defined, both valid for 4 cycles -> vid_req_ready=1 all 4 cycles and cpu_req_ready=0; the CPU is granted the first cycle vid_req_valid drops.

Source files
------------

// File: rtl/ram_access_arbiter.sv
// ---------------------------------------------------------------------------
// RamAccessArbiter (module ram_access_arbiter)
//
// Purpose:
//   Merges two clients onto the single port of the 128-bit, byte-enabled,
//   unaligned-address data RAM. Client 0 is the CPU load/store unit (read and
//   write). Client 1 is the HDMI frame reader (read only). Reads in flight are
//   tracked in a short shift pipe so that each read response is registered and
//   returned to the client that issued it.
//
// Build option:
//   VIDEO_PRIORITY_EN - when defined, the video client wins every conflict
//                       (fixed priority), and the CPU may starve. When
//                       undefined, conflicts are resolved round robin.
//
// Parameters:
//   READ_LATENCY  cycles from a RAM address edge to valid ram_data_out (1..4)
//   ADDR_W        byte-address width
//   DATA_W        data width; byte-enable width is DATA_W/8
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   cpu_req_*                 CPU request (valid/ready, write, address, data,
//                             byte enables)
//   cpu_resp_valid/_data      CPU read response (one-cycle pulse, data held)
//   vid_req_*                 video read request (valid/ready, address)
//   vid_resp_valid/_data      video read response (one-cycle pulse, data held)
//   ram_address, ram_data_in,
//   ram_byte_enablers,
//   ram_write_enable          RAM request side, driven by the granted client
//   ram_data_out              RAM read data
// ---------------------------------------------------------------------------
module ram_access_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 128
) (
  input  logic                clock,
  input  logic                reset,

  input  logic                cpu_req_valid,
  output logic                cpu_req_ready,
  input  logic                cpu_req_write,
  input  logic [ADDR_W-1:0]   cpu_req_address,
  input  logic [DATA_W-1:0]   cpu_req_data,
  input  logic [DATA_W/8-1:0] cpu_req_byte_enablers,
  output logic                cpu_resp_valid,
  output logic [DATA_W-1:0]   cpu_resp_data,

  input  logic                vid_req_valid,
  output logic                vid_req_ready,
  input  logic [ADDR_W-1:0]   vid_req_address,
  output logic                vid_resp_valid,
  output logic [DATA_W-1:0]   vid_resp_data,

  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W-1:0]   ram_data_in,
  output logic [DATA_W/8-1:0] ram_byte_enablers,
  output logic                ram_write_enable,
  input  logic [DATA_W-1:0]   ram_data_out
);

  localparam int BE_W = DATA_W / 8;

  // Grant decision for the current cycle
  logic w_grantCpu;
  logic w_grantVid;
  logic w_acceptRead;

  // Combinational RAM drive, and the copy held while nobody is granted
  logic [ADDR_W-1:0] w_ramAddress;
  logic [DATA_W-1:0] w_ramDataIn;
  logic [BE_W-1:0]   w_ramByteEnablers;
  logic              w_ramWriteEnable;
  logic [ADDR_W-1:0] r_ramAddress;
  logic [DATA_W-1:0] r_ramDataIn;
  logic [BE_W-1:0]   r_ramByteEnablers;

  // Read tracking pipe; client bit is 1 for video, 0 for CPU
  logic [READ_LATENCY-1:0] r_pipeValid;
  logic [READ_LATENCY-1:0] r_pipeClient;
  logic                    w_tailValid;
  logic                    w_tailClient;

  // Registered responses
  logic              r_cpuRespValid;
  logic [DATA_W-1:0] r_cpuRespData;
  logic              r_vidRespValid;
  logic [DATA_W-1:0] r_vidRespData;

`ifdef VIDEO_PRIORITY_EN
  // Fixed priority: the HDMI line deadline beats the CPU every time.
  always_comb begin
    w_grantCpu = 1'b0;
    w_grantVid = 1'b0;
    if (!reset) begin
      w_grantVid = vid_req_valid;
      w_grantCpu = cpu_req_valid && !vid_req_valid;
    end
  end
`else
  // Remembers who was granted last so that a conflict goes to the other one.
  // Resetting to "video" makes the CPU win the very first conflict.
  logic r_lastGrantVid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lastGrantVid <= 1'b1;
    end else if (w_grantCpu) begin
      r_lastGrantVid <= 1'b0;
    end else if (w_grantVid) begin
      r_lastGrantVid <= 1'b1;
    end
  end

  // Round robin: a lone requester always wins; on a conflict the client that
  // was not granted last wins. Nothing is granted while reset is held.
  always_comb begin
    w_grantCpu = 1'b0;
    w_grantVid = 1'b0;
    if (!reset) begin
      if (cpu_req_valid && vid_req_valid) begin
        w_grantCpu = r_lastGrantVid;
        w_grantVid = !r_lastGrantVid;
      end else begin
        w_grantCpu = cpu_req_valid;
        w_grantVid = vid_req_valid;
      end
    end
  end
`endif

  assign cpu_req_ready = w_grantCpu;
  assign vid_req_ready = w_grantVid;
  assign w_acceptRead  = (w_grantCpu && !cpu_req_write) || w_grantVid;

  // RAM drive: the granted client's fields pass straight through. The video
  // client can never write, so its enables are forced low. With no grant the
  // last driven fields are replayed from the holding registers.
  always_comb begin
    w_ramAddress      = r_ramAddress;
    w_ramDataIn       = r_ramDataIn;
    w_ramByteEnablers = r_ramByteEnablers;
    w_ramWriteEnable  = 1'b0;
    if (reset) begin
      w_ramAddress      = '0;
      w_ramDataIn       = '0;
      w_ramByteEnablers = '0;
    end else if (w_grantCpu) begin
      w_ramAddress      = cpu_req_address;
      w_ramDataIn       = cpu_req_data;
      w_ramByteEnablers = cpu_req_byte_enablers;
      w_ramWriteEnable  = cpu_req_write;
    end else if (w_grantVid) begin
      w_ramAddress      = vid_req_address;
      w_ramDataIn       = '0;
      w_ramByteEnablers = '0;
    end
  end

  // Holding registers capture whatever was driven on a granted cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ramAddress      <= '0;
      r_ramDataIn       <= '0;
      r_ramByteEnablers <= '0;
    end else if (w_grantCpu || w_grantVid) begin
      r_ramAddress      <= w_ramAddress;
      r_ramDataIn       <= w_ramDataIn;
      r_ramByteEnablers <= w_ramByteEnablers;
    end
  end

  assign ram_address       = w_ramAddress;
  assign ram_data_in       = w_ramDataIn;
  assign ram_byte_enablers = w_ramByteEnablers;
  assign ram_write_enable  = w_ramWriteEnable;

  // Read tracking: one entry enters every cycle (valid only for an accepted
  // read) and walks down the pipe in step with the RAM's read latency, so the
  // tail entry lines up exactly with the matching ram_data_out.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pipeValid  <= '0;
      r_pipeClient <= '0;
    end else begin
      r_pipeValid[0]  <= w_acceptRead;
      r_pipeClient[0] <= w_grantVid;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipeValid[i]  <= r_pipeValid[i-1];
        r_pipeClient[i] <= r_pipeClient[i-1];
      end
    end
  end

  assign w_tailValid  = r_pipeValid[READ_LATENCY-1];
  assign w_tailClient = r_pipeClient[READ_LATENCY-1];

  // Response capture: the owner's data register loads ram_data_out and its
  // valid pulses alongside for exactly one cycle. Data stays put until that
  // client's next response.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cpuRespValid <= 1'b0;
      r_cpuRespData  <= '0;
      r_vidRespValid <= 1'b0;
      r_vidRespData  <= '0;
    end else begin
      r_cpuRespValid <= w_tailValid && !w_tailClient;
      r_vidRespValid <= w_tailValid && w_tailClient;
      if (w_tailValid && !w_tailClient) begin
        r_cpuRespData <= ram_data_out;
      end
      if (w_tailValid && w_tailClient) begin
        r_vidRespData <= ram_data_out;
      end
    end
  end

  // A response already registered when reset arrives belongs to a request
  // from before reset, so it is masked rather than delivered.
  assign cpu_resp_valid = r_cpuRespValid && !reset;
  assign vid_resp_valid = r_vidRespValid && !reset;
  assign cpu_resp_data  = r_cpuRespData;
  assign vid_resp_data  = r_vidRespData;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for ram_access_arbiter. A behavioural byte-addressed RAM with a
// one-cycle read latency and write-before-read ordering sits on the RAM side.
// Memory starts as byte[a] = a[7:0] ^ 8'h5A, with bytes 0x13..0x22 preloaded
// to 0x00..0x0F.
// ---------------------------------------------------------------------------
module tb_ram_access_arbiter;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 128;
  localparam int BE_W   = DATA_W / 8;

  logic              clock;
  logic              reset;
  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic              cpu_req_write;
  logic [ADDR_W-1:0] cpu_req_address;
  logic [DATA_W-1:0] cpu_req_data;
  logic [BE_W-1:0]   cpu_req_byte_enablers;
  logic              cpu_resp_valid;
  logic [DATA_W-1:0] cpu_resp_data;
  logic              vid_req_valid;
  logic              vid_req_ready;
  logic [ADDR_W-1:0] vid_req_address;
  logic              vid_resp_valid;
  logic [DATA_W-1:0] vid_resp_data;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in;
  logic [BE_W-1:0]   ram_byte_enablers;
  logic              ram_write_enable;
  logic [DATA_W-1:0] ram_data_out;

  int checkCount = 0;
  int failCount  = 0;

  ram_access_arbiter #(
    .READ_LATENCY(1),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cpu_req_valid(cpu_req_valid),
    .cpu_req_ready(cpu_req_ready),
    .cpu_req_write(cpu_req_write),
    .cpu_req_address(cpu_req_address),
    .cpu_req_data(cpu_req_data),
    .cpu_req_byte_enablers(cpu_req_byte_enablers),
    .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_data(cpu_resp_data),
    .vid_req_valid(vid_req_valid),
    .vid_req_ready(vid_req_ready),
    .vid_req_address(vid_req_address),
    .vid_resp_valid(vid_resp_valid),
    .vid_resp_data(vid_resp_data),
    .ram_address(ram_address),
    .ram_data_in(ram_data_in),
    .ram_byte_enablers(ram_byte_enablers),
    .ram_write_enable(ram_write_enable),
    .ram_data_out(ram_data_out)
  );

  // Free-running clock, 10 time units per cycle
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural RAM: initialises itself on the first edge, then applies the
  // write before sampling the read so a read right after a write sees it.
  logic [7:0] mem [0:65535];
  logic       memReady = 1'b0;

  always @(posedge clock) begin
    logic [DATA_W-1:0] readWord;
    logic [15:0]       idx;
    if (!memReady) begin
      for (int a = 0; a < 65536; a++) begin
        mem[a] = 8'(a) ^ 8'h5A;
      end
      for (int a = 0; a < 16; a++) begin
        mem[16'h0013 + 16'(a)] = 8'(a);
      end
      memReady = 1'b1;
    end
    if (ram_write_enable) begin
      for (int i = 0; i < BE_W; i++) begin
        idx = ram_address[15:0] + 16'(i);
        if (ram_byte_enablers[i]) mem[idx] = ram_data_in[i*8 +: 8];
      end
    end
    for (int i = 0; i < BE_W; i++) begin
      idx = ram_address[15:0] + 16'(i);
      readWord[i*8 +: 8] = mem[idx];
    end
    ram_data_out <= readWord;
  end

  typedef struct {
    logic              cpuValid;
    logic [ADDR_W-1:0] cpuAddr;
    logic              vidValid;
    logic [ADDR_W-1:0] vidAddr;
    logic              expCpuReady;
    logic              expVidReady;
    logic              expCpuResp;
    logic              expVidResp;
    logic [7:0]        expCpuByte;
    logic [7:0]        expVidByte;
  } stimVec_t;

  stimVec_t vecs [10];

  function automatic stimVec_t mkVec(input logic cv, input logic [ADDR_W-1:0] ca,
                                     input logic vv, input logic [ADDR_W-1:0] va,
                                     input logic cr, input logic vr,
                                     input logic cp, input logic vp,
                                     input logic [7:0] cb, input logic [7:0] vb);
    stimVec_t v;
    v.cpuValid = cv;  v.cpuAddr = ca;  v.vidValid = vv;  v.vidAddr = va;
    v.expCpuReady = cr;  v.expVidReady = vr;
    v.expCpuResp = cp;  v.expVidResp = vp;
    v.expCpuByte = cb;  v.expVidByte = vb;
    return v;
  endfunction

  // Compares one observed value against its expected value
  task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drives every request input for the coming cycle
  task automatic applyStimulus(input logic cv, input logic cw, input logic [ADDR_W-1:0] ca,
                               input logic [DATA_W-1:0] cd, input logic [BE_W-1:0] cbe,
                               input logic vv, input logic [ADDR_W-1:0] va);
    cpu_req_valid         = cv;
    cpu_req_write         = cw;
    cpu_req_address       = ca;
    cpu_req_data          = cd;
    cpu_req_byte_enablers = cbe;
    vid_req_valid         = vv;
    vid_req_address       = va;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  // Inputs change 1 unit after the rising edge; outputs are sampled mid-cycle
  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " cpu_req_ready"}, 128'(cpu_req_ready), '0);
    checkOutput({tag, " vid_req_ready"}, 128'(vid_req_ready), '0);
    checkOutput({tag, " cpu_resp_valid"}, 128'(cpu_resp_valid), '0);
    checkOutput({tag, " vid_resp_valid"}, 128'(vid_resp_valid), '0);
    checkOutput({tag, " cpu_resp_data"}, cpu_resp_data, '0);
    checkOutput({tag, " vid_resp_data"}, vid_resp_data, '0);
    checkOutput({tag, " ram_write_enable"}, 128'(ram_write_enable), '0);
    checkOutput({tag, " ram_address"}, 128'(ram_address), '0);
    checkOutput({tag, " ram_data_in"}, ram_data_in, '0);
    checkOutput({tag, " ram_byte_enablers"}, 128'(ram_byte_enablers), '0);
  endtask

  logic [DATA_W-1:0] expWord;
  logic [15:0]       laneAddr;
  int                numVecs;

  initial begin
    $display("[TB] starting ram_access_arbiter bench");
    reset = 1'b1;
    idle();

    // Reset with a CPU request present: no grant may leak through
    nextCycle();
    applyStimulus(1'b1, 1'b0, 20'h00013, '0, '0, 1'b1, 20'h00040);
    sample();
    checkOutput("ready during reset cpu", 128'(cpu_req_ready), '0);
    checkOutput("ready during reset vid", 128'(vid_req_ready), '0);
    nextCycle();
    reset = 1'b0;
    idle();
    sample();
    checkAllZero("reset state");

    // Single CPU read of 0x00013: lanes return 0x00..0x0F, two cycles later
    nextCycle();
    applyStimulus(1'b1, 1'b0, 20'h00013, '0, '0, 1'b0, '0);
    sample();
    checkOutput("rd1 cpu_req_ready", 128'(cpu_req_ready), 128'd1);
    checkOutput("rd1 ram_address", 128'(ram_address), 128'h13);
    checkOutput("rd1 ram_write_enable", 128'(ram_write_enable), '0);
    nextCycle();
    idle();
    sample();
    checkOutput("rd1 early resp", 128'(cpu_resp_valid), '0);
    nextCycle();
    sample();
    for (int i = 0; i < BE_W; i++) expWord[i*8 +: 8] = 8'(i);
    checkOutput("rd1 cpu_resp_valid", 128'(cpu_resp_valid), 128'd1);
    checkOutput("rd1 cpu_resp_data", cpu_resp_data, expWord);
    checkOutput("rd1 vid_resp_valid", 128'(vid_resp_valid), '0);
    nextCycle();
    sample();
    checkOutput("rd1 pulse ends", 128'(cpu_resp_valid), '0);
    checkOutput("rd1 data held", cpu_resp_data, expWord);

    // CPU write to 0x00005 (lanes 0..3), then read 0x00004 straight after
    nextCycle();
    applyStimulus(1'b1, 1'b1, 20'h00005, {16{8'h11}}, 16'h000F, 1'b0, '0);
    sample();
    checkOutput("wr ram_write_enable", 128'(ram_write_enable), 128'd1);
    checkOutput("wr ram_byte_enablers", 128'(ram_byte_enablers), 128'h000F);
    checkOutput("wr ram_address", 128'(ram_address), 128'h5);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 20'h00004, '0, '0, 1'b0, '0);
    sample();
    checkOutput("raw read we low", 128'(ram_write_enable), '0);
    checkOutput("raw read ready", 128'(cpu_req_ready), 128'd1);
    nextCycle();
    idle();
    sample();
    checkOutput("write gives no resp", 128'(cpu_resp_valid), '0);
    nextCycle();
    sample();
    for (int i = 0; i < BE_W; i++) begin
      laneAddr = 16'h0004 + 16'(i);
      if (laneAddr >= 16'h0005 && laneAddr <= 16'h0008) expWord[i*8 +: 8] = 8'h11;
      else if (laneAddr >= 16'h0013 && laneAddr <= 16'h0022) expWord[i*8 +: 8] = 8'(laneAddr - 16'h0013);
      else expWord[i*8 +: 8] = laneAddr[7:0] ^ 8'h5A;
    end
    checkOutput("raw cpu_resp_valid", 128'(cpu_resp_valid), 128'd1);
    checkOutput("raw cpu_resp_data", cpu_resp_data, expWord);
    nextCycle();
    sample();
    checkOutput("raw pulse ends", 128'(cpu_resp_valid), '0);

    // Video read while the idle CPU inputs carry write fields and enables
    nextCycle();
    applyStimulus(1'b0, 1'b1, 20'h00300, {16{8'hEE}}, 16'hFFFF, 1'b1, 20'h00340);
    sample();
    checkOutput("vid vid_req_ready", 128'(vid_req_ready), 128'd1);
    checkOutput("vid cpu_req_ready", 128'(cpu_req_ready), '0);
    checkOutput("vid ram_write_enable", 128'(ram_write_enable), '0);
    checkOutput("vid ram_byte_enablers", 128'(ram_byte_enablers), '0);
    checkOutput("vid ram_address", 128'(ram_address), 128'h340);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 20'h00300, {16{8'hEE}}, 16'hFFFF, 1'b0, 20'h00340);
    sample();
    checkOutput("vid idle we low", 128'(ram_write_enable), '0);
    checkOutput("vid idle be held", 128'(ram_byte_enablers), '0);
    nextCycle();
    idle();
    sample();
    for (int i = 0; i < BE_W; i++) expWord[i*8 +: 8] = (8'h40 + 8'(i)) ^ 8'h5A;
    checkOutput("vid vid_resp_valid", 128'(vid_resp_valid), 128'd1);
    checkOutput("vid vid_resp_data", vid_resp_data, expWord);
    checkOutput("vid cpu_resp_valid", 128'(cpu_resp_valid), '0);
    checkOutput("vid ram untouched", 128'(mem[16'h0340]), 128'h1A);

    // Conflict table from a fresh reset
    nextCycle();
    reset = 1'b1;
    idle();
    nextCycle();
    reset = 1'b0;
`ifdef VIDEO_PRIORITY_EN
    vecs[0] = mkVec(1, 20'h100, 1, 20'h240, 0, 1, 0, 0, 8'h00, 8'h00);
    vecs[1] = mkVec(1, 20'h100, 1, 20'h250, 0, 1, 0, 0, 8'h00, 8'h00);
    vecs[2] = mkVec(1, 20'h100, 1, 20'h260, 0, 1, 0, 1, 8'h00, 8'h1A);
    vecs[3] = mkVec(1, 20'h100, 1, 20'h270, 0, 1, 0, 1, 8'h00, 8'h0A);
    vecs[4] = mkVec(1, 20'h100, 0, 20'h000, 1, 0, 0, 1, 8'h00, 8'h3A);
    vecs[5] = mkVec(0, 20'h000, 0, 20'h000, 0, 0, 0, 1, 8'h00, 8'h2A);
    vecs[6] = mkVec(0, 20'h000, 0, 20'h000, 0, 0, 1, 0, 8'h5A, 8'h00);
    vecs[7] = mkVec(0, 20'h000, 0, 20'h000, 0, 0, 0, 0, 8'h00, 8'h00);
    numVecs = 8;
`else
    vecs[0] = mkVec(1, 20'h100, 1, 20'h240, 1, 0, 0, 0, 8'h00, 8'h00);
    vecs[1] = mkVec(1, 20'h110, 1, 20'h240, 0, 1, 0, 0, 8'h00, 8'h00);
    vecs[2] = mkVec(1, 20'h110, 1, 20'h250, 1, 0, 1, 0, 8'h5A, 8'h00);
    vecs[3] = mkVec(1, 20'h120, 1, 20'h250, 0, 1, 0, 1, 8'h00, 8'h1A);
    vecs[4] = mkVec(1, 20'h120, 1, 20'h260, 1, 0, 1, 0, 8'h4A, 8'h00);
    vecs[5] = mkVec(1, 20'h130, 1, 20'h260, 0, 1, 0, 1, 8'h00, 8'h0A);
    vecs[6] = mkVec(1, 20'h130, 0, 20'h000, 1, 0, 1, 0, 8'h7A, 8'h00);
    vecs[7] = mkVec(0, 20'h000, 0, 20'h000, 0, 0, 0, 1, 8'h00, 8'h3A);
    vecs[8] = mkVec(0, 20'h000, 0, 20'h000, 0, 0, 1, 0, 8'h6A, 8'h00);
    vecs[9] = mkVec(0, 20'h000, 0, 20'h000, 0, 0, 0, 0, 8'h00, 8'h00);
    numVecs = 10;
`endif
    for (int v = 0; v < numVecs; v++) begin
      applyStimulus(vecs[v].cpuValid, 1'b0, vecs[v].cpuAddr, '0, '0,
                    vecs[v].vidValid, vecs[v].vidAddr);
      sample();
      checkOutput($sformatf("arb[%0d] cpu_req_ready", v), 128'(cpu_req_ready), 128'(vecs[v].expCpuReady));
      checkOutput($sformatf("arb[%0d] vid_req_ready", v), 128'(vid_req_ready), 128'(vecs[v].expVidReady));
      checkOutput($sformatf("arb[%0d] cpu_resp_valid", v), 128'(cpu_resp_valid), 128'(vecs[v].expCpuResp));
      checkOutput($sformatf("arb[%0d] vid_resp_valid", v), 128'(vid_resp_valid), 128'(vecs[v].expVidResp));
      checkOutput($sformatf("arb[%0d] ram_write_enable", v), 128'(ram_write_enable), '0);
      if (vecs[v].expCpuResp)
        checkOutput($sformatf("arb[%0d] cpu byte0", v), 128'(cpu_resp_data[7:0]), 128'(vecs[v].expCpuByte));
      if (vecs[v].expVidResp)
        checkOutput($sformatf("arb[%0d] vid byte0", v), 128'(vid_resp_data[7:0]), 128'(vecs[v].expVidByte));
      nextCycle();
    end

    // Two reads in flight, then a one-cycle reset: nothing may come back
    applyStimulus(1'b1, 1'b0, 20'h00100, '0, '0, 1'b0, '0);
    sample();
    checkOutput("rst cpu accepted", 128'(cpu_req_ready), 128'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 20'h00240);
    sample();
    checkOutput("rst vid accepted", 128'(vid_req_ready), 128'd1);
    nextCycle();
    idle();
    reset = 1'b1;
    sample();
    checkOutput("rst cycle cpu_resp_valid", 128'(cpu_resp_valid), '0);
    checkOutput("rst cycle vid_resp_valid", 128'(vid_resp_valid), '0);
    nextCycle();
    reset = 1'b0;
    sample();
    checkAllZero("after reset");
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      sample();
      checkOutput($sformatf("post reset %0d cpu_resp_valid", c), 128'(cpu_resp_valid), '0);
      checkOutput($sformatf("post reset %0d vid_resp_valid", c), 128'(vid_resp_valid), '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
